// File: rtl/bcd_to_binary_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM encoding, default
// widths, the reverse-double-dabble correction constants and range limits.
// Optional feature macro used by the top: BCD_TO_BINARY_SATURATE_EN.
package bcd_to_binary_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int DEFAULT_BITS   = 10;
    localparam int DEFAULT_NUMBER = 4;

    // A BCD digit reaching 8 after a right shift must be reduced by 3.
    localparam int CORR_THRESHOLD = 8;
    localparam int CORR_OFFSET    = 3;

    // Largest legal decimal digit.
    localparam int DIGIT_MAX = 9;

    // Range limits of the default-width signed result.
    localparam int MAX_POS = 511;
    localparam int MAX_NEG = 512;

endpackage

// File: rtl/bcd_to_binary_digit_correct.sv
// One BCD digit correction stage of reverse double dabble: after a right
// shift, a digit that reads 8 or more is reduced by 3.
module bcd_digit_correct
    import bcd_to_binary_pkg::*;
#(
    parameter int number = DEFAULT_NUMBER
) (
    input  logic [number-1:0] digit_i,
    output logic [number-1:0] digit_o
);

    // Subtract the correction offset from digits at or above the threshold.
    always_comb begin
        if (digit_i >= number'(CORR_THRESHOLD)) begin
            digit_o = digit_i - number'(CORR_OFFSET);
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential signed three-digit BCD to two's-complement converter using
// reverse double dabble, one shift/correct step per clock.
// Build option: define BCD_TO_BINARY_SATURATE_EN to clamp overflowing
// results; otherwise overflowing results wrap to the low result bits.
module bcd_to_binary
    import bcd_to_binary_pkg::*;
#(
    parameter int bits   = DEFAULT_BITS,
    parameter int number = DEFAULT_NUMBER
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              negative,
    input  logic [number-1:0] hundred,
    input  logic [number-1:0] ten,
    input  logic [number-1:0] one,
    output logic [bits-1:0]   binary,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int BcdW = 3 * number;
    localparam int RegW = BcdW + bits;
    localparam int CntW = $clog2(bits + 1);

    // The shared limits describe the default width; other widths derive theirs.
    localparam int MaxPos = (bits == DEFAULT_BITS) ? MAX_POS : (1 << (bits - 1)) - 1;
    localparam int MaxNeg = (bits == DEFAULT_BITS) ? MAX_NEG : (1 << (bits - 1));

    state_t            state_q, state_d;
    logic [RegW-1:0]   shift_q, shift_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              negative_q, negative_d;
    logic              invalid_q, invalid_d;
    logic [bits-1:0]   binary_q, binary_d;
    logic              error_q, error_d;
    logic              done_q, done_d;

    logic [RegW-1:0]   shifted;
    logic [RegW-1:0]   stepped;
    logic [number-1:0] corrHundred, corrTen, corrOne;
    logic [bits-1:0]   mag;
    logic [bits-1:0]   magNeg;
    logic [bits:0]     limit;
    logic              overflow;
    logic [bits-1:0]   wrapped;
    logic [bits-1:0]   result;
    logic              digitBad;

    assign shifted = shift_q >> 1;

    bcd_digit_correct #(.number(number)) uHundred (
        .digit_i(shifted[RegW-1 -: number]),
        .digit_o(corrHundred)
    );

    bcd_digit_correct #(.number(number)) uTen (
        .digit_i(shifted[RegW-1-number -: number]),
        .digit_o(corrTen)
    );

    bcd_digit_correct #(.number(number)) uOne (
        .digit_i(shifted[RegW-1-2*number -: number]),
        .digit_o(corrOne)
    );

    // Form one conversion step and the final signed result from the register.
    always_comb begin
        stepped  = {corrHundred, corrTen, corrOne, shifted[bits-1:0]};
        mag      = shift_q[bits-1:0];
        magNeg   = ~mag + bits'(1);
        limit    = negative_q ? (bits+1)'(MaxNeg) : (bits+1)'(MaxPos);
        overflow = (|shift_q[RegW-1:bits]) || ({1'b0, mag} > limit);
        wrapped  = negative_q ? magNeg : mag;
`ifdef BCD_TO_BINARY_SATURATE_EN
        if (overflow) begin
            result = negative_q ? {1'b1, {(bits-1){1'b0}}} : {1'b0, {(bits-1){1'b1}}};
        end else begin
            result = wrapped;
        end
`else
        result = wrapped;
`endif
        digitBad = (hundred > number'(DIGIT_MAX)) || (ten > number'(DIGIT_MAX)) ||
                   (one > number'(DIGIT_MAX));
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            count_q    <= '0;
            negative_q <= 1'b0;
            invalid_q  <= 1'b0;
            binary_q   <= '0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            negative_q <= negative_d;
            invalid_q  <= invalid_d;
            binary_q   <= binary_d;
            error_q    <= error_d;
            done_q     <= done_d;
        end
    end

    // Next state: capture in IDLE, step in CONVERT, publish in DONE.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        count_d    = count_q;
        negative_d = negative_q;
        invalid_d  = invalid_q;
        binary_d   = binary_q;
        error_d    = error_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d    = {hundred, ten, one, {bits{1'b0}}};
                    count_d    = '0;
                    negative_d = negative;
                    invalid_d  = digitBad;
                    state_d    = digitBad ? DONE : CONVERT;
                end
            end
            CONVERT: begin
                shift_d = stepped;
                count_d = count_q + CntW'(1);
                if (count_q == CntW'(bits - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d   = 1'b1;
                error_d  = invalid_q | overflow;
                binary_d = invalid_q ? '0 : result;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: busy decodes CONVERT, the rest come straight from registers.
    always_comb begin
        busy   = (state_q == CONVERT);
        done   = done_q;
        binary = binary_q;
        error  = error_q;
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: stimulus pushes expected results,
// a monitor pops and compares them on every done pulse.
module tb_bcd_to_binary;

    typedef struct {
        logic [9:0] bin;
        logic       err;
        int         at;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       start;
    logic       negative;
    logic [3:0] hundred, ten, one;
    logic [9:0] binary;
    logic       busy, done, error;

    int   cycle;
    int   checks;
    int   failures;
    exp_t sb[$];

    bcd_to_binary uDut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .negative(negative),
        .hundred(hundred),
        .ten(ten),
        .one(one),
        .binary(binary),
        .busy(busy),
        .done(done),
        .error(error)
    );

    // Free-running clock with a period of 10 time units.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Edge counter used to check latency.
    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cycle);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("binary", 32'(binary), 32'(e.bin));
                checkOutput("error", 32'(error), 32'(e.err));
                checkOutput("latency", 32'(cycle), 32'(e.at));
            end
        end
    end

    task automatic waitDrain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clock);
        @(negedge clock);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d expected=0 pending", sb.size());
            sb.delete();
        end
    endtask

    task automatic applyStimulus(input logic neg, input logic [3:0] h, input logic [3:0] t,
                                 input logic [3:0] o, input logic [9:0] expBin,
                                 input logic expErr, input int lat);
        exp_t e;
        @(negedge clock);
        reset    = 1'b1;
        negative = neg;
        hundred  = h;
        ten      = t;
        one      = o;
        start    = 1'b1;
        @(posedge clock);
        #1;
        e.bin = expBin;
        e.err = expErr;
        e.at  = cycle + lat;
        sb.push_back(e);
        start    = 1'b0;
        negative = ~neg;
        hundred  = 4'h7;
        ten      = 4'h7;
        one      = 4'h7;
        checkOutput("busy_after_start", 32'(busy), 32'(lat != 1));
        @(negedge clock);
        if (lat == 1) checkOutput("busy_invalid", 32'(busy), 32'(0));
        waitDrain();
        checkOutput("hold_binary", 32'(binary), 32'(expBin));
        checkOutput("hold_error", 32'(error), 32'(expErr));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        exp_t e;
        int   k;
        cycle    = 0;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        start    = 1'b0;
        negative = 1'b0;
        hundred  = 4'h0;
        ten      = 4'h0;
        one      = 4'h0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_binary", 32'(binary), 32'(0));
        checkOutput("reset_busy", 32'(busy), 32'(0));
        checkOutput("reset_done", 32'(done), 32'(0));
        checkOutput("reset_error", 32'(error), 32'(0));

        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 10'h000, 1'b0, 11);
        applyStimulus(1'b1, 4'h1, 4'h2, 4'h3, 10'h385, 1'b0, 11);
`ifdef BCD_TO_BINARY_SATURATE_EN
        applyStimulus(1'b0, 4'h9, 4'h9, 4'h9, 10'h1FF, 1'b1, 11);
        applyStimulus(1'b0, 4'h5, 4'h1, 4'h2, 10'h1FF, 1'b1, 11);
        applyStimulus(1'b1, 4'h9, 4'h9, 4'h9, 10'h200, 1'b1, 11);
        applyStimulus(1'b1, 4'h5, 4'h1, 4'h3, 10'h200, 1'b1, 11);
`else
        applyStimulus(1'b0, 4'h9, 4'h9, 4'h9, 10'h3E7, 1'b1, 11);
        applyStimulus(1'b0, 4'h5, 4'h1, 4'h2, 10'h200, 1'b1, 11);
        applyStimulus(1'b1, 4'h9, 4'h9, 4'h9, 10'h019, 1'b1, 11);
        applyStimulus(1'b1, 4'h5, 4'h1, 4'h3, 10'h1FF, 1'b1, 11);
`endif
        applyStimulus(1'b0, 4'h5, 4'h1, 4'h1, 10'h1FF, 1'b0, 11);
        applyStimulus(1'b1, 4'h5, 4'h1, 4'h2, 10'h200, 1'b0, 11);
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 10'h000, 1'b0, 11);
        applyStimulus(1'b0, 4'h2, 4'h5, 4'h5, 10'h0FF, 1'b0, 11);
        applyStimulus(1'b0, 4'h0, 4'hA, 4'h0, 10'h000, 1'b1, 1);
        applyStimulus(1'b1, 4'h0, 4'h4, 4'h2, 10'h3D6, 1'b0, 11);
        applyStimulus(1'b0, 4'hF, 4'h0, 4'h0, 10'h000, 1'b1, 1);

        // Reset in the middle of a conversion: no result may follow.
        @(negedge clock);
        negative = 1'b0;
        hundred  = 4'h1;
        ten      = 4'h0;
        one      = 4'h0;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("midreset_busy", 32'(busy), 32'(0));
        checkOutput("midreset_done", 32'(done), 32'(0));
        checkOutput("midreset_binary", 32'(binary), 32'(0));
        checkOutput("midreset_error", 32'(error), 32'(0));
        @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);

        // Start held high: one accept per return to IDLE.
        @(negedge clock);
        negative = 1'b0;
        hundred  = 4'h0;
        ten      = 4'h4;
        one      = 4'h2;
        start    = 1'b1;
        @(posedge clock);
        #1;
        k     = cycle;
        e.bin = 10'h02A;
        e.err = 1'b0;
        e.at  = k + 11;
        sb.push_back(e);
        e.at  = k + 23;
        sb.push_back(e);
        repeat (19) @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        waitDrain();
        repeat (15) @(negedge clock);
        checkOutput("held_start_binary", 32'(binary), 32'(10'h02A));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary.md
BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 SHALL have parameter bits, default 10, meaning width of the two's-complement result.
REQ-002 SHALL have parameter number, default 4, meaning width of each BCD digit.
REQ-003 SHALL have port clock  input  1  single rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  conversion request, sampled only in IDLE.
REQ-006 SHALL have port negative  input  1  sign of the decimal value (1 = negative).
REQ-007 SHALL have port hundred, ten, one  input  number each  BCD digits.
REQ-008 SHALL have port binary  output  bits  two's-complement result, registered.
REQ-009 SHALL have port busy  output  1  high while in CONVERT.
REQ-010 SHALL have port done  output  1  one-cycle pulse when binary/error are updated.
REQ-011 SHALL have port error  output  1  invalid digit or range overflow, registered with done.

Function
REQ-012 SHALL use FSM states IDLE, CONVERT and DONE; reset enters IDLE.
REQ-013 IDLE with start=1 at edge k SHALL capture digits and sign into internal registers, clear the bit counter and go to CONVERT.
REQ-014 At that same edge, if any digit is >9, SHALL bypass CONVERT and go to DONE with binary=0 and error=1.
REQ-015 CONVERT SHALL run reverse double dabble, one step per cycle, for exactly bits cycles (edges k+1..k+bits).
REQ-016 Each reverse-double-dabble step SHALL shift the {BCD, magnitude} register right by one, then subtract 3 from every digit that is >=8.
REQ-017 At edge k+bits+1, DONE SHALL load binary and error and assert done for exactly one cycle, then return to IDLE.
REQ-018 Total latency SHALL be bits+1 cycles from the start edge to the done cycle (11 for defaults).
REQ-019 For negative=1, binary SHALL be the two's complement of the magnitude (~mag+1); negative zero SHALL yield 0.
REQ-020 The valid range SHALL be -2^(bits-1)..2^(bits-1)-1 (-512..511); a magnitude outside it SHALL set error=1 with binary per REQ-026.
REQ-021 binary and error SHALL hold their values until the next done.
REQ-022 start SHALL be ignored while in CONVERT or DONE, with no queuing.
REQ-023 Input digit changes after the start edge SHALL NOT affect the result.

Reset
REQ-024 With reset=0 at a clock edge, SHALL set state=IDLE, binary=0, busy=0, done=0, error=0 and clear internal registers, including mid-CONVERT; no done SHALL follow.
REQ-025 The first start SHALL be accepted at the first edge with reset=1.

Configuration
REQ-026 Macro BCD_TO_BINARY_SATURATE_EN SHALL control overflow results.
- Defined: overflow clamps binary to 2^(bits-1)-1 (positive) or -2^(bits-1) (negative).
- Undefined: binary = low bits of the signed two's-complement result (wrap).
- error=1 on overflow in both builds.

Structure
REQ-027 A shared package SHALL hold the state encoding, default widths, the correction constants 8 and 3, and the range limits (MAX_POS=511, MAX_NEG=512).
REQ-028 SHALL use one sub-module, bcd_digit_correct (number-bit combinational: subtract 3 if >=8), instantiated per digit.

Verification
REQ-029 Scenario: +0/0/0, start -> done 11 cycles later, binary=10'h000, error=0.
REQ-030 Scenario: -1/2/3 -> binary=10'h385 (-123), error=0; +9/9/9 -> error=1 (saturate build 10'h1FF, wrap build 10'h3E7).
REQ-031 Scenario: +5/1/1 -> 10'h1FF, error=0; -5/1/2 -> 10'h200, error=0; +5/1/2 -> error=1 (saturate 10'h1FF, wrap 10'h200).
REQ-032 Scenario: ten=4'hA, start -> done on the next cycle, binary=0, error=1, busy never high.
REQ-033 Scenario: reset=0 at CONVERT cycle 5 -> next cycle busy=0, done=0, binary=0; no done pulse follows.
REQ-034 Scenario: start held high for 20 cycles with +0/4/2 -> exactly one done per accepted start, each with binary=10'h02A and a new start accepted only in IDLE.
